// File: rtl/reg_resp_pkg.sv
// Shared types and constants for the reg_resp register-file responder.
package reg_resp_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 7;

  localparam logic [ADDR_W-1:0] ADDR_ERR_CNT = 7'h7E;
  localparam logic [ADDR_W-1:0] ADDR_ID      = 7'h7F;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_DATA,
    RD_RESP
  } resp_state_e;

endpackage

// File: rtl/reg_resp.sv
// Register-file responder: general RW registers, a clear-on-write error
// counter and a read-only ID, behind a command/write-data/read-response protocol.
module reg_resp
  import reg_resp_pkg::*;
#(
  parameter int                NUM_REGS = 16,
  parameter logic [DATA_W-1:0] ID_VALUE = 8'hA5,
  parameter int                TIMEOUT  = 255
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       cmd_valid_i,
  input  logic                       wr_i,
  input  logic [ADDR_W-1:0]          address_i,
  input  logic                       write_valid_i,
  input  logic [DATA_W-1:0]          write_data_i,
  output logic                       read_received_o,
  output logic [DATA_W-1:0]          read_data_o,
  output logic                       busy_o,
  output logic [NUM_REGS*DATA_W-1:0] regs_o
);

  resp_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        tmo_q, tmo_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_recv_q, rd_recv_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  logic              is_gp;
  logic [DATA_W-1:0] rd_val;
  logic              err_evt;
  logic              err_clr;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    tmo_d     = tmo_q;
    rd_data_d = rd_data_q;
    rd_recv_d = 1'b0;
    regs_d    = regs_q;
    err_evt   = 1'b0;
    err_clr   = 1'b0;
    is_gp     = 1'b0;
    rd_val    = '0;

    // Decode the latched address once; unmapped reads fall through as zero.
    for (int k = 0; k < NUM_REGS; k++) begin
      if (addr_q == ADDR_W'(k)) begin
        is_gp  = 1'b1;
        rd_val = regs_q[k];
      end
    end
    if (addr_q == ADDR_ERR_CNT) rd_val = err_cnt_q;
    if (addr_q == ADDR_ID)      rd_val = ID_VALUE;

    case (state_q)
      IDLE: begin
        if (write_valid_i) err_evt = 1'b1;
        if (cmd_valid_i) begin
          addr_d = address_i;
          if (wr_i) begin
            state_d = WAIT_DATA;
            tmo_d   = '0;
          end else begin
            state_d = RD_RESP;
          end
        end
      end
      WAIT_DATA: begin
        if (cmd_valid_i) err_evt = 1'b1;
        // Data arriving on the timeout cycle still completes the write.
        if (write_valid_i) begin
          state_d = IDLE;
          if (is_gp) begin
            for (int k = 0; k < NUM_REGS; k++) begin
              if (addr_q == ADDR_W'(k)) regs_d[k] = write_data_i;
            end
          end else if (addr_q == ADDR_ERR_CNT) begin
            err_clr = 1'b1;
          end else begin
            err_evt = 1'b1;
          end
        end else if (tmo_q == 8'(TIMEOUT - 1)) begin
          state_d = IDLE;
          err_evt = 1'b1;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      RD_RESP: begin
        rd_data_d = rd_val;
        rd_recv_d = 1'b1;
        state_d   = IDLE;
        if (!(is_gp || addr_q == ADDR_ERR_CNT || addr_q == ADDR_ID)) err_evt = 1'b1;
        if (cmd_valid_i || write_valid_i) err_evt = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Clear beats increment; several errors in one cycle count once.
    if (err_clr)                            err_cnt_d = '0;
    else if (err_evt && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    else                                    err_cnt_d = err_cnt_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      tmo_q     <= '0;
      err_cnt_q <= '0;
      rd_data_q <= '0;
      rd_recv_q <= 1'b0;
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      tmo_q     <= tmo_d;
      err_cnt_q <= err_cnt_d;
      rd_data_q <= rd_data_d;
      rd_recv_q <= rd_recv_d;
      regs_q    <= regs_d;
    end
  end

  assign busy_o          = (state_q != IDLE);
  assign read_received_o = rd_recv_q;
  assign read_data_o     = rd_data_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
    assign regs_o[g*DATA_W +: DATA_W] = regs_q[g];
  end

endmodule

// File: doc/reg_resp.md
Name: reg_resp

Overview:
Register-file responder on the reg_top side of the command interface. It accepts read and write commands (write flag plus 7-bit address), holds a bank of general-purpose registers and two special registers, and returns read data with a one-cycle strobe. It detects protocol and address errors, counts them in a saturating error counter, and exports the register bank to the rest of the design.

Parameters:
NUM_REGS, 16, number of general RW registers at addresses 0..NUM_REGS-1; legal range 1..126.
ID_VALUE, 8'hA5, constant returned by the ID register.
TIMEOUT, 255, cycles to wait in WAIT_DATA for write data before aborting; legal range 2..255.

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  synchronous reset, active-high
cmd_valid_i  input  1  one-cycle command strobe; wr_i and address_i are valid in this cycle
wr_i  input  1  1 = write, 0 = read
address_i  input  7  register address
write_valid_i  input  1  one-cycle strobe; write_data_i is valid in this cycle
write_data_i  input  8  write payload
read_received_o  output  1  one-cycle strobe; read_data_o is valid in this cycle
read_data_o  output  8  read payload, registered
busy_o  output  1  high whenever the FSM is not in IDLE
regs_o  output  NUM_REGS*8  flattened general registers; reg k is at bits [8k+7:8k]

Behaviour:
- Interface: one clock (clk_i); reset rst_i is synchronous and active-high.
- Reset: FSM goes to IDLE. All general registers, err_cnt, read_data_o, read_received_o and busy_o are 0. Reset asserted mid-transaction aborts the transaction silently, with no write and no error counted.
- Address map:
  - 0..NUM_REGS-1: general RW registers.
  - 7'h7E: ERR_CNT. A read returns the count; a write of any value clears it to 0.
  - 7'h7F: ID. Read-only; returns ID_VALUE.
  - Any other address is unmapped.
- FSM states and transitions:
  - IDLE:
    - cmd_valid_i with wr_i=1: latch the address, go to WAIT_DATA, clear the timeout counter.
    - cmd_valid_i with wr_i=0: latch the address, go to RD_RESP.
    - write_valid_i alone: ignored, counted as an error.
  - WAIT_DATA:
    - write_valid_i: perform the write to the latched address, return to IDLE next cycle.
    - Otherwise the timeout counter increments. When it reaches TIMEOUT-1 with no write_valid_i, return to IDLE and count an error.
    - If write_valid_i and the timeout occur in the same cycle, the write wins and no error is counted.
  - RD_RESP: lasts exactly 1 cycle. Register the read data into read_data_o and set read_received_o=1 for the following cycle, then return to IDLE.
- Read latency: cmd_valid_i in cycle N puts read_received_o=1 in cycle N+2. A new command is accepted in cycle N+2. read_data_o holds its value until the next read response.
- Write effect: a register write is visible on regs_o in the cycle after write_valid_i.
- Errors (each increments err_cnt):
  - read or write to an unmapped address; such reads return 8'h00 with a normal strobe, such writes are dropped;
  - write to ID; the write is dropped;
  - cmd_valid_i while busy_o=1; the command is ignored and the current transaction continues;
  - stray write_valid_i in IDLE or RD_RESP;
  - WAIT_DATA timeout.
- err_cnt rules:
  - 8-bit and saturating at 8'hFF.
  - Multiple error events in one cycle add only 1.
  - A clear write and an increment in the same cycle: clear wins, result 0.
- Read of ERR_CNT returns the value at the RD_RESP cycle, before any increment in that cycle.

Decomposition:
- Package reg_resp_pkg holds:
  - enum resp_state_e {IDLE, WAIT_DATA, RD_RESP};
  - localparams ADDR_ERR_CNT=7'h7E and ADDR_ID=7'h7F;
  - DATA_W=8 and ADDR_W=7.
- No sub-module. The register bank, timeout counter and error counter are inline, with a single always_comb next-state block plus an always_ff.

Test Plan:
- Write then read: cmd(wr=1, addr=3), then write_valid with 8'h5C, then cmd(wr=0, addr=3) -> read_received_o 2 cycles after the read cmd, read_data_o=8'h5C, regs_o[31:24]=8'h5C.
- ID and protection: read 7'h7F -> 8'hA5. Write 8'h00 to 7'h7F, then read 7'h7F -> still 8'hA5, and ERR_CNT reads 1.
- Timeout with TIMEOUT=4: cmd(wr=1, addr=0) and no data -> busy_o drops after 4 cycles, ERR_CNT=1, reg0 unchanged. Repeat with write_valid arriving exactly on the timeout cycle -> write lands, ERR_CNT unchanged.
- Collision: cmd_valid in the cycle after a read cmd -> ignored. The original read completes normally, ERR_CNT increments by exactly 1.
- Saturation and clear: 300 unmapped reads of 7'h50 -> each returns 8'h00, ERR_CNT=8'hFF. Then write 7'h7E while a stray write_valid occurs in the same cycle -> ERR_CNT=0.
- Reset mid-write: cmd(wr=1, addr=2), then rst_i for 1 cycle, then write_valid with 8'h11 -> write ignored (counted as stray, ERR_CNT=1), reg2=0, busy_o=0.
